// File: rtl/piso_scan_ctrl.sv
// piso_scan_ctrl: sequencer for a daisy chain of HC165-style 8-bit PISO
// shift registers. It drives the chain's load, shift-clock and inhibit
// strobes and deserialises sr_q into one W-bit frame. Each completed frame
// is flagged by a one-cycle data_valid pulse.
// Optional macro PISO_SCAN_CHANGE_DET_EN: when defined, changed pulses with
// data_valid whenever the new frame differs from the previous one. The first
// frame after reset always counts as a change. When the macro is undefined,
// changed is tied low.
module piso_scan_ctrl #(
    parameter  int CHAIN_LEN = 2,
    parameter  int CLK_DIV   = 4,
    localparam int W         = 8 * CHAIN_LEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         auto_scan,
    input  logic         sr_q,
    output logic         sr_clk,
    output logic         sr_shld,
    output logic         sr_clk_inh,
    output logic         busy,
    output logic [W-1:0] data,
    output logic         data_valid,
    output logic         changed
);

    localparam int DIV_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
    localparam int CNT_W = $clog2(W + 1);

    localparam logic [DIV_W-1:0] LOAD_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] ALL_BITS  = CNT_W'(W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] bit_cnt;
    logic [W-1:0]     sreg;

`ifdef PISO_SCAN_CHANGE_DET_EN
    logic [W-1:0]     prev_frame;
    logic             first_frame;
`else
    assign changed = 1'b0;
`endif

    // Scan sequencer: state, strobes and frame capture all registered so the
    // chain sees glitch-free edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sreg       <= '0;
            sr_clk     <= 1'b0;
            sr_shld    <= 1'b1;
            sr_clk_inh <= 1'b1;
            busy       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
`ifdef PISO_SCAN_CHANGE_DET_EN
            changed     <= 1'b0;
            prev_frame  <= '0;
            first_frame <= 1'b1;
`endif
        end else begin
            data_valid <= 1'b0;
`ifdef PISO_SCAN_CHANGE_DET_EN
            changed    <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    sr_clk     <= 1'b0;
                    sr_clk_inh <= 1'b1;
                    if (start || auto_scan) begin
                        state   <= LOAD;
                        sr_shld <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        sr_shld <= 1'b1;
                    end
                end

                LOAD: begin
                    if (div_cnt == LOAD_LAST) begin
                        state      <= SETTLE;
                        div_cnt    <= '0;
                        sr_shld    <= 1'b1;
                        sr_clk_inh <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SETTLE: begin
                    if (div_cnt == HALF_LAST) begin
                        state   <= SHIFT_LO;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                // sr_q is sampled on the same edge that raises sr_clk, so the
                // value captured is the bit presented before the chain advances.
                SHIFT_LO: begin
                    if (div_cnt == HALF_LAST) begin
                        sreg    <= {sreg[W-2:0], sr_q};
                        state   <= SHIFT_HI;
                        sr_clk  <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT_HI: begin
                    if (div_cnt == HALF_LAST) begin
                        div_cnt <= '0;
                        sr_clk  <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            state      <= DONE;
                            bit_cnt    <= ALL_BITS;
                            sr_clk_inh <= 1'b1;
                        end else begin
                            state   <= SHIFT_LO;
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                DONE: begin
                    data       <= sreg;
                    data_valid <= 1'b1;
                    sr_clk     <= 1'b0;
                    sr_clk_inh <= 1'b1;
                    div_cnt    <= '0;
`ifdef PISO_SCAN_CHANGE_DET_EN
                    changed     <= first_frame || (sreg != prev_frame);
                    prev_frame  <= sreg;
                    first_frame <= 1'b0;
`endif
                    if (auto_scan) begin
                        state   <= LOAD;
                        sr_shld <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    sr_clk     <= 1'b0;
                    sr_shld    <= 1'b1;
                    sr_clk_inh <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
